// File: rtl/vliw_fwd_scoreboard.sv
// Forwarding scoreboard for a multi-lane VLIW pipeline: per-operand bypass select and load-use stall.
// Optional statistics counters (fwd_cnt, stall_cnt) are built when VLIW_FWD_STATS_EN is defined.
module vliw_fwd_scoreboard #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned SW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int unsigned FW    = 1 + SW + LW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ex_valid,
  input  logic [LANES*2*REG_AW-1:0]    ex_src,
  input  logic [LANES*REG_AW-1:0]      ex_dst,
  input  logic [LANES-1:0]             ex_we,
  input  logic [LANES-1:0]             ex_load,
  input  logic                         flush,
  output logic [LANES*2*FW-1:0]        fwd_sel,
  output logic                         stall
`ifdef VLIW_FWD_STATS_EN
  ,
  output logic [15:0]                  fwd_cnt,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int unsigned NOPS = LANES * 2;

  logic [DEPTH-1:0][LANES-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][LANES-1:0]             ld_q,  ld_d;
  logic [DEPTH-1:0][LANES-1:0][REG_AW-1:0] dst_q, dst_d;

  logic [REG_AW-1:0] src [NOPS];
  logic              ld_match;

  always_comb begin
    for (int unsigned o = 0; o < NOPS; o++) begin
      src[o] = ex_src[o*REG_AW +: REG_AW];
    end
  end

  always_comb begin
    ld_match = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned o = 0; o < NOPS; o++) begin
        if (vld_q[0][l] && ld_q[0][l] && (src[o] != '0) && (src[o] == dst_q[0][l])) begin
          ld_match = 1'b1;
        end
      end
    end
    stall = ex_valid & ~flush & ld_match;
  end

  // Scan oldest stage first and lanes ascending so the youngest stage / highest lane overwrites.
  always_comb begin
    fwd_sel = '0;
    for (int unsigned o = 0; o < NOPS; o++) begin
      for (int unsigned si = 0; si < DEPTH; si++) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (vld_q[DEPTH-1-si][l] && !((DEPTH-1-si == 0) && ld_q[DEPTH-1-si][l]) &&
              (src[o] != '0) && (src[o] == dst_q[DEPTH-1-si][l])) begin
            fwd_sel[o*FW +: FW] = {1'b1, SW'(DEPTH-1-si), LW'(l)};
          end
        end
      end
    end
  end

  always_comb begin
    for (int unsigned s = 1; s < DEPTH; s++) begin
      vld_d[s] = vld_q[s-1];
      ld_d[s]  = ld_q[s-1];
      dst_d[s] = dst_q[s-1];
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      dst_d[0][l] = ex_dst[l*REG_AW +: REG_AW];
      ld_d[0][l]  = ex_load[l];
      vld_d[0][l] = ex_valid & ex_we[l] & ~stall & (ex_dst[l*REG_AW +: REG_AW] != '0);
    end
    if (flush) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ld_q  <= '0;
      dst_q <= '0;
    end else begin
      vld_q <= vld_d;
      ld_q  <= ld_d;
      dst_q <= dst_d;
    end
  end

`ifdef VLIW_FWD_STATS_EN
  localparam int unsigned CW = $clog2(NOPS + 1);

  logic [CW-1:0] hit_cnt;
  logic [16:0]   fwd_sum;
  logic [15:0]   fwd_cnt_q, stall_cnt_q;

  always_comb begin
    hit_cnt = '0;
    for (int unsigned o = 0; o < NOPS; o++) begin
      hit_cnt = hit_cnt + CW'(fwd_sel[o*FW + FW - 1]);
    end
    fwd_sum = {1'b0, fwd_cnt_q} + 17'(hit_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (ex_valid && !stall) begin
        fwd_cnt_q <= fwd_sum[16] ? '1 : fwd_sum[15:0];
      end
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign fwd_cnt   = fwd_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
